// File: rtl/intt16_if.sv
// Stream bundle for the 16-point inverse NTT: coefficient input port, twiddle
// parameters, and the indexed result output port.
interface intt16_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] q;
    logic [W-1:0] w_inv;
    logic [W-1:0] n_inv;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [3:0]   out_idx;
    logic         busy;

    modport master (
        output in_valid, in_data, q, w_inv, n_inv, out_ready,
        input  in_ready, out_valid, out_data, out_idx, busy
    );

    modport slave (
        input  in_valid, in_data, q, w_inv, n_inv, out_ready,
        output in_ready, out_valid, out_data, out_idx, busy
    );
endinterface

// File: rtl/intt16_seq.sv
// Sequential 16-point inverse NTT: loads 16 coefficients, runs one modular MAC per
// cycle (16 MACs + 1 scale per output row), then streams the 16 results out.
module intt16_seq #(
    parameter int N = 16,
    parameter int W = 8
) (
    input  logic     clk,
    input  logic     rst,
    intt16_if.slave  bus
);
    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_FINISH  = 2'd2;
    localparam logic [1:0] ST_OUTPUT  = 2'd3;
    localparam logic [3:0] LAST       = 4'(N - 1);
    localparam logic [4:0] SCALE_COL  = 5'(N);
    localparam int         CW         = 2 * W;

    logic [1:0]   state_q, state_d;
    logic [3:0]   load_cnt_q, load_cnt_d;
    logic [4:0]   col_q, col_d;
    logic [3:0]   row_q, row_d;
    logic [3:0]   k_q, k_d;
    logic [W-1:0] mod_q, mod_d;
    logic [W-1:0] winv_q, winv_d;
    logic [W-1:0] ninv_q, ninv_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] tw_q, tw_d;
    logic [W-1:0] step_q, step_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
    logic [W-1:0] a_q   [16];
    logic [W-1:0] a_d   [16];
    logic [W-1:0] res_q [16];
    logic [W-1:0] res_d [16];

    // A zero modulus is replaced by 1 so the divider never sees 0; x % 1 is 0,
    // which gives the required all-zero output for q < 2.
    function automatic logic [W-1:0] mod_red(input logic [CW-1:0] x, input logic [W-1:0] m);
        logic [CW-1:0] div;
        logic [CW-1:0] r;
        div = (m == '0) ? CW'(1) : {{W{1'b0}}, m};
        r   = x % div;
        return r[W-1:0];
    endfunction

    logic [W-1:0]  beat_mod;
    logic [W-1:0]  in_red;
    logic [W-1:0]  winv_red;
    logic [W-1:0]  ninv_red;
    logic [W-1:0]  a_cur;
    logic [CW-1:0] mac_sum;
    logic [W-1:0]  mac_acc;
    logic [W-1:0]  tw_next;
    logic [W-1:0]  scaled;
    logic [W-1:0]  step_next;

    // Beat 0 must be reduced by the modulus arriving alongside it, not the stale register.
    assign beat_mod  = (load_cnt_q == 4'd0) ? bus.q : mod_q;
    assign in_red    = mod_red(CW'(bus.in_data), beat_mod);
    assign winv_red  = mod_red(CW'(bus.w_inv), bus.q);
    assign ninv_red  = mod_red(CW'(bus.n_inv), bus.q);

    assign a_cur     = a_q[col_q[3:0]];
    assign mac_sum   = CW'(acc_q) + CW'(a_cur) * CW'(tw_q);
    assign mac_acc   = mod_red(mac_sum, mod_q);
    assign tw_next   = mod_red(CW'(tw_q) * CW'(step_q), mod_q);
    assign scaled    = mod_red(CW'(acc_q) * CW'(ninv_q), mod_q);
    assign step_next = mod_red(CW'(step_q) * CW'(winv_q), mod_q);

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        k_d         = k_q;
        mod_d       = mod_q;
        winv_d      = winv_q;
        ninv_d      = ninv_q;
        acc_d       = acc_q;
        tw_d        = tw_q;
        step_d      = step_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        a_d         = a_q;
        res_d       = res_q;

        case (state_q)
            ST_LOAD: begin
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    a_d[load_cnt_q] = in_red;
                    if (load_cnt_q == 4'd0) begin
                        mod_d  = bus.q;
                        winv_d = winv_red;
                        ninv_d = ninv_red;
                    end
                    if (load_cnt_q == LAST) begin
                        load_cnt_d = 4'd0;
                        state_d    = ST_COMPUTE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                        row_d      = 4'd0;
                        col_d      = 5'd0;
                        acc_d      = '0;
                        tw_d       = W'(1);
                        step_d     = W'(1);
                    end else begin
                        load_cnt_d = load_cnt_q + 4'd1;
                    end
                end
            end
            ST_COMPUTE: begin
                if (col_q == SCALE_COL) begin
                    res_d[row_q] = scaled;
                    step_d       = step_next;
                    acc_d        = '0;
                    tw_d         = W'(1);
                    col_d        = 5'd0;
                    if (row_q == LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end else begin
                    acc_d = mac_acc;
                    tw_d  = tw_next;
                    col_d = col_q + 5'd1;
                end
            end
            ST_FINISH: begin
                // One settling cycle after the final scale write before results are presented.
                state_d     = ST_OUTPUT;
                out_valid_d = 1'b1;
                k_d         = 4'd0;
            end
            ST_OUTPUT: begin
                if (bus.out_ready) begin
                    if (k_q == LAST) begin
                        state_d     = ST_LOAD;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        in_ready_d  = 1'b1;
                        k_d         = 4'd0;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= 4'd0;
            col_q       <= 5'd0;
            row_q       <= 4'd0;
            k_q         <= 4'd0;
            mod_q       <= '0;
            winv_q      <= '0;
            ninv_q      <= '0;
            acc_q       <= '0;
            tw_q        <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                a_q[i]   <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            k_q         <= k_d;
            mod_q       <= mod_d;
            winv_q      <= winv_d;
            ninv_q      <= ninv_d;
            acc_q       <= acc_d;
            tw_q        <= tw_d;
            step_q      <= step_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            for (int i = 0; i < 16; i++) begin
                a_q[i]   <= a_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? res_q[k_q] : '0;
    assign bus.out_idx   = k_q;
    assign bus.busy      = busy_q;
endmodule
